// File: rtl/anim_pkg.sv
// Shared types for the frame-rate animation sequencer: mode and FSM encodings, direction constants.
package anim_pkg;

    typedef enum logic [1:0] {
        LOOP     = 2'd0,
        ONESHOT  = 2'd1,
        PINGPONG = 2'd2,
        HOLD     = 2'd3
    } anim_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } anim_fsm_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/anim_sequencer_frame_tick_sync.sv
// frame_tick_sync: brings an asynchronous frame clock into the i_clk domain and emits a
// single-cycle tick per rising edge of that frame clock.
module frame_tick_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_tick_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_delay;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_delay <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_delay <= r_sync2;
        end
    end

    assign o_tick_c = r_sync2 & ~r_delay;

endmodule

// File: rtl/anim_sequencer.sv
// anim_sequencer: advances an animation index every eff_period frame ticks in loop, one-shot,
// ping-pong or hold mode. Optional register override of the index under ANIM_SW_OVERRIDE_EN.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int unsigned STATE_W        = 6,
    parameter int unsigned NUM_STATES     = 32,
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned DEFAULT_PERIOD = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_clk,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [CNT_W-1:0]   i_period,
`ifdef ANIM_SW_OVERRIDE_EN
    input  logic               i_sw_ovr,
    input  logic [STATE_W-1:0] i_sw,
`endif
    output logic [STATE_W-1:0] o_anim_state,
    output logic               o_busy,
    output logic               o_wrap_pulse,
    output logic               o_done
);

    localparam int unsigned IDX_W = STATE_W + 1;
    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

    logic               w_tick;
    anim_fsm_e          r_fsm;
    anim_mode_e         r_mode;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_dir;
    logic [STATE_W-1:0] r_idx;
    logic               r_busy;
    logic               r_wrap;
    logic               r_done;

    frame_tick_sync u_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_async  (i_frame_clk),
        .o_tick_c (w_tick)
    );

    // Control FSM and index sequencing; stop beats start, start swallows a coincident tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm       <= IDLE;
            r_mode      <= LOOP;
            r_period    <= CNT_W'(DEFAULT_PERIOD);
            r_frame_cnt <= '0;
            r_dir       <= DIR_UP;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            if (i_stop) begin
                r_fsm       <= IDLE;
                r_frame_cnt <= '0;
                r_dir       <= DIR_UP;
                r_idx       <= '0;
                r_busy      <= 1'b0;
            end else if (i_start) begin
                r_fsm       <= RUN;
                r_mode      <= anim_mode_e'(i_mode);
                r_period    <= (i_period == '0) ? CNT_W'(DEFAULT_PERIOD) : i_period;
                r_frame_cnt <= '0;
                r_dir       <= DIR_UP;
                r_idx       <= '0;
                r_busy      <= 1'b1;
            end else if ({1'b0, r_idx} >= IDX_W'(NUM_STATES)) begin
                r_idx <= '0;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        r_idx  <= '0;
                        r_busy <= 1'b0;
                    end
                    RUN: begin
                        if (w_tick) begin
                            if (r_frame_cnt == r_period - CNT_W'(1)) begin
                                r_frame_cnt <= '0;
                                case (r_mode)
                                    LOOP: begin
                                        if (r_idx == LAST) begin
                                            r_idx  <= '0;
                                            r_wrap <= 1'b1;
                                        end else begin
                                            r_idx <= r_idx + STATE_W'(1);
                                        end
                                    end
                                    ONESHOT: begin
                                        if (r_idx == LAST) begin
                                            r_fsm  <= DONE;
                                            r_busy <= 1'b0;
                                            r_done <= 1'b1;
                                        end else begin
                                            r_idx <= r_idx + STATE_W'(1);
                                        end
                                    end
                                    PINGPONG: begin
                                        // Reverse on arriving at an end so the ends are not repeated.
                                        if (r_dir == DIR_UP) begin
                                            r_idx <= r_idx + STATE_W'(1);
                                            if (r_idx + STATE_W'(1) == LAST) begin
                                                r_dir  <= DIR_DOWN;
                                                r_wrap <= 1'b1;
                                            end
                                        end else begin
                                            r_idx <= r_idx - STATE_W'(1);
                                            if (r_idx == STATE_W'(1)) begin
                                                r_dir  <= DIR_UP;
                                                r_wrap <= 1'b1;
                                            end
                                        end
                                    end
                                    default: ;
                                endcase
                            end else begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: r_busy <= 1'b0;
                    default: begin
                        r_fsm  <= IDLE;
                        r_idx  <= '0;
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ANIM_SW_OVERRIDE_EN
    logic               r_ovr;
    logic [STATE_W-1:0] r_sw;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovr <= 1'b0;
            r_sw  <= '0;
        end else begin
            r_ovr <= i_sw_ovr;
            r_sw  <= ({1'b0, i_sw} >= IDX_W'(NUM_STATES)) ? '0 : i_sw;
        end
    end

    assign o_anim_state = r_ovr ? r_sw : r_idx;
`else
    assign o_anim_state = r_idx;
`endif

    assign o_busy       = r_busy;
    assign o_wrap_pulse = r_wrap;
    assign o_done       = r_done;

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: an arithmetic model of the animation sequence predicts
// every observable output change; a monitor pops and compares each change the DUT presents.
module tb_anim_sequencer;

    localparam int N    = 32;
    localparam int DEFP = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] period = 6'd0;
    logic [5:0] anim_state;
    logic       busy;
    logic       wrap_pulse;
    logic       done;
`ifdef ANIM_SW_OVERRIDE_EN
    logic       sw_ovr = 1'b0;
    logic [5:0] sw = 6'd0;
`endif

    anim_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame_clk  (frame_clk),
        .i_start      (start),
        .i_stop       (stop),
        .i_mode       (mode),
        .i_period     (period),
`ifdef ANIM_SW_OVERRIDE_EN
        .i_sw_ovr     (sw_ovr),
        .i_sw         (sw),
`endif
        .o_anim_state (anim_state),
        .o_busy       (busy),
        .o_wrap_pulse (wrap_pulse),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] st;
        logic       busy;
        logic       wrap;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: 0 idle, 1 run, 2 done; position derived from ticks since start.
    int m_fsm = 0;
    int m_mode = 0;
    int m_per = DEFP;
    int m_ticks = 0;
    int m_idx = 0;
    bit m_busy = 0;

    task automatic push_if(input int nidx, input bit nbusy, input bit w, input bit d);
        exp_t e;
        if (nidx != m_idx || nbusy != m_busy || w || d) begin
            e.st = 6'(nidx);
            e.busy = nbusy;
            e.wrap = w;
            e.done = d;
            q.push_back(e);
        end
        m_idx = nidx;
        m_busy = nbusy;
    endtask

    task automatic model_start(input int md, input int per);
        m_fsm = 1;
        m_mode = md;
        m_per = (per == 0) ? DEFP : per;
        m_ticks = 0;
        push_if(0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_idle();
        m_fsm = 0;
        push_if(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_tick();
        int s;
        int p;
        if (m_fsm != 1) return;
        m_ticks++;
        if (m_ticks % m_per != 0) return;
        s = m_ticks / m_per;
        case (m_mode)
            0: push_if(s % N, 1'b1, (s % N) == 0, 1'b0);
            1: begin
                if (s < N) push_if(s, 1'b1, 1'b0, 1'b0);
                else begin
                    m_fsm = 2;
                    push_if(N - 1, 1'b0, 1'b0, 1'b1);
                end
            end
            2: begin
                p = s % (2 * N - 2);
                push_if((p < N) ? p : (2 * N - 2 - p), 1'b1, (p == N - 1) || (p == 0), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scramble_inputs();
        mode = 2'($urandom_range(0, 3));
        period = 6'($urandom_range(0, 63));
    endtask

    task automatic do_start(input int md, input int per);
        mode = 2'(md);
        period = 6'(per);
        start = 1'b1;
        model_start(md, per);
        cyc(1);
        start = 1'b0;
        scramble_inputs();
        cyc(1);
    endtask

    task automatic do_frame();
        model_tick();
        frame_clk = 1'b1;
        cyc(4);
        frame_clk = 1'b0;
        cyc(3);
    endtask

    task automatic check_now(input string name, input logic [8:0] got, input logic [8:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got {state,busy,wrap,done}=%h required %h", name, got, req);
        end
    endtask

    // Monitor: every observable output change is one scoreboard comparison.
    initial begin
        logic [5:0] ps;
        logic       pb;
        exp_t       e;
        ps = '0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (anim_state !== ps || busy !== pb || wrap_pulse !== 1'b0 || done !== 1'b0) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got state=%0d busy=%0b wrap=%0b done=%0b, required no change",
                             anim_state, busy, wrap_pulse, done);
                end else begin
                    e = q.pop_front();
                    if ({anim_state, busy, wrap_pulse, done} !== e) begin
                        n_fail++;
                        $display("FAIL event: got state=%0d busy=%0b wrap=%0b done=%0b, required state=%0d busy=%0b wrap=%0b done=%0b",
                                 anim_state, busy, wrap_pulse, done, e.st, e.busy, e.wrap, e.done);
                    end
                end
            end
            ps = anim_state;
            pb = busy;
        end
    end

    initial begin
        int r;
        cyc(3);
        check_now("reset_state", {anim_state, busy, wrap_pulse, done}, 9'h0);
        rst = 1'b0;
        cyc(2);

        // Tick latency: index moves on the 3rd clock edge after frame_clk is sampled high.
        do_start(0, 1);
        model_tick();
        frame_clk = 1'b1;
        cyc(1);
        check_now("latency_edge1", {3'b0, anim_state}, 9'd0);
        cyc(1);
        check_now("latency_edge2", {3'b0, anim_state}, 9'd0);
        cyc(1);
        check_now("latency_edge3", {3'b0, anim_state}, 9'd1);
        frame_clk = 1'b0;
        cyc(4);

        // Loop with default period: full cycle back to 0 with one wrap.
        do_start(0, 0);
        for (int i = 0; i < N * DEFP; i++) do_frame();
        check_now("loop_full_cycle", {anim_state, busy, wrap_pulse, done}, {6'd0, 3'b100});

        // One-shot: done once, then index held through extra frames.
        do_start(1, 2);
        for (int i = 0; i < 2 * N + 6; i++) do_frame();
        check_now("oneshot_hold", {anim_state, busy, wrap_pulse, done}, {6'(N - 1), 3'b000});

        // Ping-pong beyond one full bounce.
        do_start(2, 1);
        for (int i = 0; i < 2 * N + 5; i++) do_frame();

        // Hold: no index movement.
        do_start(3, 1);
        for (int i = 0; i < 5; i++) do_frame();

        // start and stop together while running: stop wins.
        do_start(0, 1);
        for (int i = 0; i < 3; i++) do_frame();
        start = 1'b1;
        stop = 1'b1;
        model_idle();
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        cyc(2);
        check_now("start_stop_same_cycle", {anim_state, busy, wrap_pulse, done}, 9'h0);

        // start coincident with tick: tick is swallowed by the restart.
        do_start(0, 1);
        for (int i = 0; i < 4; i++) do_frame();
        frame_clk = 1'b1;
        cyc(2);
        mode = 2'd0;
        period = 6'd1;
        start = 1'b1;
        model_start(0, 1);
        cyc(1);
        start = 1'b0;
        cyc(2);
        frame_clk = 1'b0;
        cyc(3);
        check_now("start_with_tick", {anim_state, busy, wrap_pulse, done}, {6'd0, 3'b100});
        do_frame();
        check_now("after_restart_tick", {3'b0, anim_state}, 9'd1);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        do_frame();
        model_idle();
        rst = 1'b1;
        #1;
        check_now("async_reset", {anim_state, busy, wrap_pulse, done}, 9'h0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Randomised mix of frames and control pulses.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                do_frame();
            end else if (r < 80) begin
                do_start($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3));
            end else if (r < 85) begin
                stop = 1'b1;
                model_idle();
                cyc(1);
                stop = 1'b0;
                cyc(1);
            end else if (r < 90) begin
                start = 1'b1;
                stop = 1'b1;
                model_idle();
                cyc(1);
                start = 1'b0;
                stop = 1'b0;
                cyc(1);
            end else if (r < 95) begin
                frame_clk = 1'b1;
                cyc(2);
                mode = 2'($urandom_range(0, 3));
                period = 6'($urandom_range(0, 3));
                start = 1'b1;
                model_start(int'(mode), int'(period));
                cyc(1);
                start = 1'b0;
                scramble_inputs();
                cyc(2);
                frame_clk = 1'b0;
                cyc(3);
            end else begin
                scramble_inputs();
                cyc($urandom_range(1, 5));
            end
        end

        cyc(5);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d undelivered expected events, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
